// File: rtl/pipeline_arith_pkg.sv
// pipeline_arith_pkg: shared constants, slice-width helper and handshake typedef for the pipelined arithmetic family
package pipeline_arith_pkg;
    localparam int BLK_W = 4;

    function automatic int calc_sw(input int width, input int stages);
        return width / stages;
    endfunction

    typedef struct packed {
        logic valid;
        logic ready;
    } vr_stage_t;
endpackage

// File: rtl/sub_block4.sv
// sub_block4: combinational 4-bit borrow block, d4 = a4 - b4 - bi computed as a4 + ~b4 + ~bi
module sub_block4
    import pipeline_arith_pkg::*;
(
    input  logic [BLK_W-1:0] a4,
    input  logic [BLK_W-1:0] b4,
    input  logic             bi,
    output logic [BLK_W-1:0] d4,
    output logic             bo
);
    logic [BLK_W:0] s;

    assign s  = {1'b0, a4} + {1'b0, ~b4} + {{BLK_W{1'b0}}, ~bi};
    assign d4 = s[BLK_W-1:0];
    assign bo = ~s[BLK_W];
endmodule

// File: rtl/pipeline_borrow_subtractor.sv
// pipeline_borrow_subtractor: STAGES-deep pipelined a - b - bin with borrow rippling one slice per cycle; SUB_OVF_EN adds the ovf port
module pipeline_borrow_subtractor
    import pipeline_arith_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int SW = calc_sw(WIDTH, STAGES);
    localparam int NB = SW / BLK_W;
    localparam int L  = STAGES - 1;

    logic [WIDTH-1:0] a_i [STAGES], b_i [STAGES], d_i [STAGES];
    logic [WIDTH-1:0] a_d [STAGES], b_d [STAGES], d_d [STAGES];
    logic [WIDTH-1:0] a_q [STAGES], b_q [STAGES], d_q [STAGES];
    logic [SW-1:0]    s_d [STAGES];
    logic             bo_s [STAGES];
    logic             br_i [STAGES], br_d [STAGES], br_q [STAGES];
    logic             v_i [STAGES], v_d [STAGES], v_q [STAGES];
    logic             en;
`ifdef SUB_OVF_EN
    logic             sa_i [STAGES], sb_i [STAGES], sa_q [STAGES], sb_q [STAGES];
`endif

    // stage inputs: stage 0 takes the offered beat, every later stage takes its predecessor's registers
    always_comb begin
        a_i[0]  = a;
        b_i[0]  = b;
        d_i[0]  = '0;
        br_i[0] = bin;
        v_i[0]  = in_valid;
`ifdef SUB_OVF_EN
        sa_i[0] = a[WIDTH-1];
        sb_i[0] = b[WIDTH-1];
`endif
        for (int k = 1; k < STAGES; k++) begin
            a_i[k]  = a_q[k-1];
            b_i[k]  = b_q[k-1];
            d_i[k]  = d_q[k-1];
            br_i[k] = br_q[k-1];
            v_i[k]  = v_q[k-1];
`ifdef SUB_OVF_EN
            sa_i[k] = sa_q[k-1];
            sb_i[k] = sb_q[k-1];
`endif
        end
    end

    genvar s, j;
    for (s = 0; s < STAGES; s++) begin : g_st
        logic [NB:0] c;
        assign c[0] = br_i[s];
        for (j = 0; j < NB; j++) begin : g_blk
            sub_block4 u_blk (
                .a4(a_i[s][s*SW + j*BLK_W +: BLK_W]),
                .b4(b_i[s][s*SW + j*BLK_W +: BLK_W]),
                .bi(c[j]),
                .d4(s_d[s][j*BLK_W +: BLK_W]),
                .bo(c[j+1])
            );
        end
        assign bo_s[s] = c[NB];
    end

    // next state: each stage resolves its own slice, drops the consumed operand slice and passes the rest on
    always_comb begin
        en = !v_q[L] || out_ready;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = a_i[k];
            a_d[k][k*SW +: SW] = '0;
            b_d[k] = b_i[k];
            b_d[k][k*SW +: SW] = '0;
            d_d[k] = d_i[k];
            d_d[k][k*SW +: SW] = s_d[k];
            br_d[k] = bo_s[k];
            v_d[k] = v_i[k];
        end
    end

    // stage registers advance together when en, otherwise the whole pipe holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                d_q[k]  <= '0;
                br_q[k] <= 1'b0;
                v_q[k]  <= 1'b0;
`ifdef SUB_OVF_EN
                sa_q[k] <= 1'b0;
                sb_q[k] <= 1'b0;
`endif
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                d_q[k]  <= d_d[k];
                br_q[k] <= br_d[k];
                v_q[k]  <= v_d[k];
`ifdef SUB_OVF_EN
                sa_q[k] <= sa_i[k];
                sb_q[k] <= sb_i[k];
`endif
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = v_q[L];
    assign diff      = d_q[L];
    assign bout      = br_q[L];
`ifdef SUB_OVF_EN
    assign ovf = (sa_q[L] != sb_q[L]) && (d_q[L][WIDTH-1] != sa_q[L]);
`endif
endmodule

// File: tb/tb_pipeline_borrow_subtractor.sv
// tb_pipeline_borrow_subtractor: randomized and directed checks against an arithmetic reference model; honours SUB_OVF_EN
module tb_pipeline_borrow_subtractor;
    localparam int W = 64;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         in_ready, out_valid, bout;
    logic [W-1:0] diff;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    pipeline_borrow_subtractor #(.WIDTH(W), .STAGES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
`ifdef SUB_OVF_EN
       ,.ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           t;
    } exp_t;

    exp_t         q[$];
    int           n_chk = 0, n_err = 0, n_out = 0, ncyc = 0, last_lat = 0;
    logic         last_fire_in = 1'b0, prev_stall = 1'b0, prev_bo = 1'b0;
    logic [W-1:0] prev_d = '0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        logic signed [W+1:0] sr;
        e.d  = x - y - W'(c);
        e.bo = ({2'b0, x} < ({2'b0, y} + (W+2)'(c)));
        sr   = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y}) - $signed({{(W+1){1'b0}}, c});
        e.ov = (sr > $signed({3'b0, {(W-1){1'b1}}})) || (sr < $signed({3'b111, {(W-1){1'b0}}}));
        e.t  = 0;
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        #1;
        last_fire_in = 1'b0;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_diff", diff, prev_d);
                chk("hold_bout", W'(bout), W'(prev_bo));
                chk("hold_valid", W'(out_valid), 1);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", W'(in_ready), 0);
            prev_stall = out_valid && !out_ready;
            prev_d     = diff;
            prev_bo    = bout;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("diff", diff, e.d);
                    chk("bout", W'(bout), W'(e.bo));
`ifdef SUB_OVF_EN
                    chk("ovf", W'(ovf), W'(e.ov));
`endif
                    last_lat = ncyc - e.t;
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                e   = ref_sub(a, b, bin);
                e.t = ncyc;
                q.push_back(e);
                last_fire_in = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n0;
        a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 20 && n_out == n0; i++) cyc();
        chk("single_count", W'(n_out - n0), 1);
        chk("latency", W'(last_lat), N);
        chk("single_pulse", W'(out_valid), 0);
    endtask

    initial begin
        int sent, n0;
        in_valid = 1'b1;
        a = 64'h1234_5678_9abc_def0;
        b = 64'h1;
        repeat (3) cyc();
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", W'(bout), 0);
`ifdef SUB_OVF_EN
        chk("rst_ovf", W'(ovf), 0);
`endif
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", W'(in_ready), 1);

        run_one(64'd5, 64'd3, 1'b0);
        run_one(64'd0, 64'd1, 1'b0);
        run_one(64'h8000_0000_0000_0000, 64'd0, 1'b1);
        run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);

        sent = 0;
        n0 = n_out;
        for (int j = 0; j < 60 && n_out - n0 < 8; j++) begin
            in_valid  = sent < 8;
            a         = W'(sent);
            b         = W'(2 * sent);
            bin       = 1'b0;
            out_ready = !(j >= 5 && j <= 10);
            cyc();
            if (last_fire_in) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("burst_count", W'(n_out - n0), 8);

        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        chk("midrst_valid", W'(out_valid), 0);
        rst = 1'b0;
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) n0++;
            cyc();
        end
        chk("post_rst_quiet", W'(n0), 0);
        run_one(64'd100, 64'd58, 1'b1);

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            a   = ($urandom % 8 == 0) ? {W{1'b1}} : {$urandom, $urandom};
            b   = ($urandom % 8 == 0) ? a : {$urandom, $urandom};
            bin = 1'($urandom);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) cyc();
        chk("drain_empty", W'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
